// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the sin/cos CORDIC.
// The word width comes from `FLOAT_BITS; it defaults to 32 when not defined by the build.
`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif

package cordic_pkg;

  localparam int unsigned WORD_BITS     = `FLOAT_BITS;
  localparam int unsigned DEF_FRAC_BITS = 16;
  localparam int unsigned DEF_ITER      = 16;
  localparam int unsigned GUARD         = 2;
  localparam int unsigned TBL_LEN       = 16;

  // Constants below are Q16; rescale() moves them to any other fraction width.
  localparam logic signed [31:0] ATAN [TBL_LEN] = '{
    32'sd51472, 32'sd30386, 32'sd16055, 32'sd8150, 32'sd4091, 32'sd2047, 32'sd1024, 32'sd512,
    32'sd256,   32'sd128,   32'sd64,    32'sd32,   32'sd16,   32'sd8,    32'sd4,    32'sd2
  };
  localparam logic signed [31:0] K_INV = 32'sd39797;
  localparam logic signed [31:0] PI    = 32'sd205887;
  localparam logic signed [31:0] PI_2  = 32'sd102943;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  function automatic logic signed [63:0] rescale(input logic signed [63:0] v,
                                                 input int unsigned frac);
    if (frac >= DEF_FRAC_BITS) return v <<< (frac - DEF_FRAC_BITS);
    return v >>> (DEF_FRAC_BITS - frac);
  endfunction

  // Past the table, atan(2^-i) equals 2^-i to well below one LSB.
  function automatic logic signed [63:0] atan_at(input int unsigned i, input int unsigned frac);
    logic [3:0] idx;
    idx = i[3:0];
    if (i < TBL_LEN) return rescale(64'(ATAN[idx]), frac);
    return 64'sd1 <<< (frac - i);
  endfunction

endpackage

// File: rtl/cordic_step.sv
// One combinational CORDIC rotation-mode iteration; the top reuses a single instance every cycle.
module cordic_step import cordic_pkg::*; #(
  parameter int unsigned WIDTH    = WORD_BITS + GUARD,
  parameter int unsigned IDX_BITS = 4
) (
  input  logic signed [WIDTH-1:0]    x,
  input  logic signed [WIDTH-1:0]    y,
  input  logic signed [WIDTH-1:0]    z,
  input  logic        [IDX_BITS-1:0] i,
  input  logic signed [WIDTH-1:0]    atan_i,
  output logic signed [WIDTH-1:0]    x_next,
  output logic signed [WIDTH-1:0]    y_next,
  output logic signed [WIDTH-1:0]    z_next
);

  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    if (!z[WIDTH-1]) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - atan_i;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + atan_i;
    end
  end

endmodule

// File: rtl/sincos_cordic.sv
// Iterative sin/cos CORDIC: FSM, iteration counter, quadrant fold and output registers.
// Define SINCOS_CACHE_EN to short-circuit a repeat of the last completed (clamped) angle.
module sincos_cordic import cordic_pkg::*; #(
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
  parameter int unsigned ITER      = DEF_ITER
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WORD_BITS-1:0] angle,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WORD_BITS-1:0] sin,
  output logic signed [WORD_BITS-1:0] cos
);

  localparam int unsigned W  = WORD_BITS;
  localparam int unsigned IW = W + GUARD;
  localparam int unsigned IF = FRAC_BITS + GUARD;
  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic signed [W-1:0]  PI_W   = W'(rescale(64'(PI), FRAC_BITS));
  localparam logic signed [W-1:0]  PI_2_W = W'(rescale(64'(PI_2), FRAC_BITS));
  localparam logic signed [IW-1:0] K_INT  = IW'(rescale(64'(K_INV), IF));

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic signed [IW-1:0]   x_q, y_q, z_q;
  logic signed [IW-1:0]   x_n, y_n, z_n, atan_i;
  logic                   neg_q, neg_d;
  logic signed [W-1:0]    a_clamp, a_red;
  logic signed [IW-1:0]   sin_full, cos_full;
  logic                   last, hit;

  always_comb begin
    a_clamp = angle;
    if (angle > PI_W)       a_clamp = PI_W;
    else if (angle < -PI_W) a_clamp = -PI_W;
    // Fold into [-pi/2, pi/2]; a half-turn only flips the sign of both outputs.
    a_red = a_clamp;
    neg_d = 1'b0;
    if (a_clamp > PI_2_W) begin
      a_red = a_clamp - PI_W;
      neg_d = 1'b1;
    end else if (a_clamp < -PI_2_W) begin
      a_red = a_clamp + PI_W;
      neg_d = 1'b1;
    end
  end

  assign atan_i   = IW'(atan_at(32'(cnt), IF));
  assign last     = (state == ROT) && (cnt == CW'(ITER - 1));
  assign sin_full = neg_q ? -y_n : y_n;
  assign cos_full = neg_q ? -x_n : x_n;

  cordic_step #(
    .WIDTH   (IW),
    .IDX_BITS(CW)
  ) u_step (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .i     (cnt),
    .atan_i(atan_i),
    .x_next(x_n),
    .y_next(y_n),
    .z_next(z_n)
  );

`ifdef SINCOS_CACHE_EN
  logic signed [W-1:0] cache_angle;
  logic                cache_vld;

  assign hit = cache_vld && (a_clamp == cache_angle);

  // The tag only becomes valid once the matching result has actually been registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_angle <= '0;
      cache_vld   <= 1'b0;
    end else if (state == IDLE && in_valid && !hit) begin
      cache_angle <= a_clamp;
      cache_vld   <= 1'b0;
    end else if (last) begin
      cache_vld   <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sin       <= '0;
      cos       <= '0;
      cnt       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      neg_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (hit) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ROT;
              x_q   <= K_INT;
              y_q   <= '0;
              z_q   <= {a_red, {GUARD{1'b0}}};
              cnt   <= '0;
              neg_q <= neg_d;
            end
          end
        end
        ROT: begin
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sin       <= sin_full[IW-1:GUARD];
            cos       <= cos_full[IW-1:GUARD];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_cordic.sv
// Self-checking bench for sincos_cordic: directed corner angles plus random angles against a
// real-arithmetic sin/cos model, with backpressure, reset-abort and repeat-angle latency checks.
module tb_sincos_cordic;

  localparam int TOL  = 10;
  localparam int PI_Q = 205887;
  localparam int ITER = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sin_o;
  logic [31:0] cos_o;

  int checks = 0;
  int errors = 0;

  // Higher-level cache model: last completed clamped angle.
  bit cache_en;
  bit have_last;
  int last_angle;

  always #5 clk = ~clk;

  sincos_cordic dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .angle    (angle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sin      (sin_o),
    .cos      (cos_o)
  );

  function automatic int clamp_q(input int a);
    if (a > PI_Q) return PI_Q;
    if (a < -PI_Q) return -PI_Q;
    return a;
  endfunction

  function automatic int ref_sin(input int a);
    real r;
    r = real'(clamp_q(a)) / 65536.0;
    return $rtoi($floor($sin(r) * 65536.0 + 0.5));
  endfunction

  function automatic int ref_cos(input int a);
    real r;
    r = real'(clamp_q(a)) / 65536.0;
    return $rtoi($floor($cos(r) * 65536.0 + 0.5));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic [31:0] obs, input int exp);
    int d;
    d = $signed(obs) - exp;
    checks++;
    assert ((d <= TOL && d >= -TOL) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, $signed(obs), exp, TOL);
    end
  endtask

  task automatic send(input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    angle    = a;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run(input logic [31:0] a, input int hold, input string tag);
    int lat, exp_lat, ca;
    logic [31:0] s, c;
    ca = clamp_q($signed(a));
    exp_lat = (cache_en && have_last && ca == last_angle) ? 0 : ITER;
    send(a);
    wait_done(lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_tol({tag, "_sin"}, sin_o, ref_sin($signed(a)));
    check_tol({tag, "_cos"}, cos_o, ref_cos($signed(a)));
    have_last  = 1'b1;
    last_angle = ca;
    s = sin_o;
    c = cos_o;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check_eq({tag, "_hold_sin"}, sin_o, s);
      check_eq({tag, "_hold_cos"}, cos_o, c);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_handoff_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_handoff_sin_held"}, sin_o, s);
  endtask

  initial begin
`ifdef SINCOS_CACHE_EN
    cache_en = 1'b1;
`else
    cache_en = 1'b0;
`endif
    have_last  = 1'b0;
    last_angle = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    angle      = '0;

    #12;
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_sin", sin_o, 32'h0);
    check_eq("reset_cos", cos_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run(32'h0000_0000, 0, "zero");
    run(32'h0001_921F, 5, "pi_2_backpressure");
    run(32'hFFFC_DBC1, 0, "minus_pi");
    run(32'h0004_0000, 1, "clamp_4p0");
    run(32'h0000_C90F, 0, "pi_4_first");
    run(32'h0000_C90F, 0, "pi_4_repeat");

    // Abort mid-rotation: everything returns to reset values straight away.
    send(32'h0001_0000);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_sin", sin_o, 32'h0);
    check_eq("abort_cos", cos_o, 32'h0);
    have_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(32'h0001_0000, 0, "after_abort");

    for (int n = 0; n < 20; n++) begin
      int a;
      a = int'($urandom_range(2 * (PI_Q + 30000))) - (PI_Q + 30000);
      run(32'(a), int'($urandom_range(2)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
